// File: rtl/hilo_unit.sv
// HI/LO register owner: sequences one in-flight MULT/DIV write-back with a timeout, plus MTHI/MTLO.
// Optional macro HILO_FWD_EN forwards an accepted result to hi_out/lo_out (and drops busy) in the done cycle.
module hilo_unit #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic             mult_done,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  input  logic             div_by_zero,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             div_zero_flag,
  output logic             timeout_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MULT_WAIT = 2'd1,
    DIV_WAIT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dzf_q, dzf_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             mult_acc_s;
  logic             div_acc_s;
  logic             cnt_last_s;
  logic             busy_base_s;

  assign mult_acc_s  = (state_q == MULT_WAIT) & mult_done;
  assign div_acc_s   = (state_q == DIV_WAIT) & div_done;
  assign cnt_last_s  = (cnt_q == CNT_LAST);
  assign busy_base_s = (state_q != IDLE) | mult_start | div_start;

  // Next-state, HI/LO write-back, sticky flags and timeout counter
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dzf_d   = dzf_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mult_start) begin
          state_d = MULT_WAIT;
          cnt_d   = {CNT_W{1'b0}};
          to_d    = 1'b0;
        end else if (div_start) begin
          state_d = DIV_WAIT;
          cnt_d   = {CNT_W{1'b0}};
          to_d    = 1'b0;
          dzf_d   = 1'b0;
        end else begin
          // MTHI/MTLO only land when nothing is being issued this cycle
          if (mthi_we) begin
            hi_d = wdata;
          end else begin
            hi_d = hi_q;
          end
          if (mtlo_we) begin
            lo_d = wdata;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      MULT_WAIT: begin
        if (mult_acc_s) begin
          hi_d    = mult_hi;
          lo_d    = mult_lo;
          state_d = IDLE;
        end else if (cnt_last_s) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DIV_WAIT: begin
        if (div_acc_s) begin
          state_d = IDLE;
          if (div_by_zero) begin
            dzf_d = 1'b1;
          end else begin
            hi_d = div_hi;
            lo_d = div_lo;
          end
        end else if (cnt_last_s) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and architectural register update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      dzf_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dzf_q   <= dzf_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

  assign div_zero_flag = dzf_q;
  assign timeout_err   = to_q;

`ifdef HILO_FWD_EN
  logic             fwd_s;
  logic [WIDTH-1:0] fwd_hi_s;
  logic [WIDTH-1:0] fwd_lo_s;

  // A zero-divisor completion carries no result, so it is not forwarded
  assign fwd_s    = mult_acc_s | (div_acc_s & ~div_by_zero);
  assign fwd_hi_s = mult_acc_s ? mult_hi : div_hi;
  assign fwd_lo_s = mult_acc_s ? mult_lo : div_lo;
  assign hi_out   = fwd_s ? fwd_hi_s : hi_q;
  assign lo_out   = fwd_s ? fwd_lo_s : lo_q;
  assign busy     = busy_base_s & ~fwd_s;
`else
  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = busy_base_s;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Directed, table-driven bench for hilo_unit; each row drives one cycle and checks pre-edge outputs.
module tb_hilo_unit;

`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, reset_n;
  logic        mult_start, div_start, mult_done, div_done, div_by_zero;
  logic        mthi_we, mtlo_we;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo, wdata;
  logic [31:0] hi_out, lo_out;
  logic        busy, div_zero_flag, timeout_err;

  int n_vec = 0;
  int n_bad = 0;

  hilo_unit #(.WIDTH(32), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .mult_start(mult_start), .div_start(div_start),
    .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo), .div_by_zero(div_by_zero),
    .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy),
    .div_zero_flag(div_zero_flag), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ms, ds, md;
    logic [31:0] mh, ml;
    logic        dd;
    logic [31:0] dh, dl;
    logic        dz, mthi, mtlo;
    logic [31:0] wd;
    logic [31:0] ehi, elo;
    logic        ebusy, edzf, eto;
  } vec_t;

  function automatic vec_t mk(input logic ms, ds, md, input logic [31:0] mh, ml,
                              input logic dd, input logic [31:0] dh, dl,
                              input logic dz, mthi, mtlo, input logic [31:0] wd,
                              input logic [31:0] ehi, elo, input logic eb, edzf, eto);
    vec_t v;
    v.ms = ms; v.ds = ds; v.md = md; v.mh = mh; v.ml = ml;
    v.dd = dd; v.dh = dh; v.dl = dl; v.dz = dz;
    v.mthi = mthi; v.mtlo = mtlo; v.wd = wd;
    v.ehi = ehi; v.elo = elo; v.ebusy = eb; v.edzf = edzf; v.eto = eto;
    return v;
  endfunction

  function automatic vec_t idle(input logic [31:0] ehi, elo, input logic eb, edzf, eto);
    return mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
              ehi, elo, eb, edzf, eto);
  endfunction

  task automatic chk(input string name, input logic [31:0] ehi, elo, input logic eb, edzf, eto);
    n_vec++;
    if (hi_out !== ehi || lo_out !== elo || busy !== eb || div_zero_flag !== edzf || timeout_err !== eto) begin
      n_bad++;
      $display("FAIL %s: got hi=%h lo=%h busy=%b dzf=%b to=%b, want hi=%h lo=%h busy=%b dzf=%b to=%b",
               name, hi_out, lo_out, busy, div_zero_flag, timeout_err, ehi, elo, eb, edzf, eto);
    end
  endtask

  task automatic apply(input vec_t v, input string name, input bit do_chk);
    @(negedge clk);
    mult_start = v.ms; div_start = v.ds; mult_done = v.md; mult_hi = v.mh; mult_lo = v.ml;
    div_done = v.dd; div_hi = v.dh; div_lo = v.dl; div_by_zero = v.dz;
    mthi_we = v.mthi; mtlo_we = v.mtlo; wdata = v.wd;
    #2;
    if (do_chk) chk(name, v.ehi, v.elo, v.ebusy, v.edzf, v.eto);
  endtask

  vec_t vecs[$];

  initial begin
    reset_n = 1'b0;
    mult_start = 1'b0; div_start = 1'b0; mult_done = 1'b0; div_done = 1'b0;
    div_by_zero = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    mult_hi = 32'h0; mult_lo = 32'h0; div_hi = 32'h0; div_lo = 32'h0; wdata = 32'h0;

    //           ms    ds    md    mh           ml            dd    dh        dl        dz    mthi  mtlo  wd            ehi                    elo                    busy
    vecs.push_back(idle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(idle(32'h0, 32'h0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h1, 32'hFFFF_FFFE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                      FWD ? 32'h1 : 32'h0, FWD ? 32'hFFFF_FFFE : 32'h0, !FWD, 1'b0, 1'b0));
    vecs.push_back(idle(32'h1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h5, 32'h1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h7, 32'h5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h5, 32'h7, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hAA, 32'hBB, 1'b1, 1'b0, 1'b0, 32'h0, 32'h5, 32'h7, 1'b1, 1'b0, 1'b0));
    vecs.push_back(idle(32'h5, 32'h7, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h5, 32'h7, 1'b1, 1'b1, 1'b0));
    vecs.push_back(idle(32'h5, 32'h7, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0, 1'b0, 32'h0,
                      FWD ? 32'h11 : 32'h5, FWD ? 32'h22 : 32'h7, !FWD, 1'b0, 1'b0));
    vecs.push_back(idle(32'h11, 32'h22, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h11, 32'h22, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h9, 32'h9, 1'b0, 1'b0, 1'b0, 32'h0, 32'h11, 32'h22, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h2, 32'h3, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                      FWD ? 32'h2 : 32'h11, FWD ? 32'h3 : 32'h22, !FWD, 1'b0, 1'b0));
    vecs.push_back(idle(32'h2, 32'h3, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hABCD, 32'h2, 32'h3, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1234, 32'hABCD, 32'hABCD, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hAAAA, 32'hBBBB, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
                      FWD ? 32'hAAAA : 32'hABCD, FWD ? 32'hBBBB : 32'hABCD, !FWD, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h5555, 32'hAAAA, 32'hBBBB, 1'b0, 1'b0, 1'b0));
    vecs.push_back(idle(32'h5555, 32'hBBBB, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h77, 32'h77, 1'b1, 32'h77, 32'h77, 1'b0, 1'b0, 1'b0, 32'h0, 32'h5555, 32'hBBBB, 1'b0, 1'b0, 1'b0));
    vecs.push_back(idle(32'h5555, 32'hBBBB, 1'b0, 1'b0, 1'b0));

    repeat (2) @(negedge clk);
    #2;
    chk("reset_hold", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("row%0d", i), 1'b1);

    // Timeout: 64 wait cycles with no done, then error and back to IDLE
    apply(mk(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
             32'h5555, 32'hBBBB, 1'b1, 1'b0, 1'b0), "to_start", 1'b1);
    for (int i = 0; i < 64; i++)
      apply(idle(32'h5555, 32'hBBBB, 1'b1, 1'b0, 1'b0), "to_last_wait", i == 63);
    apply(idle(32'h5555, 32'hBBBB, 1'b0, 1'b0, 1'b1), "to_fire", 1'b1);
    apply(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0,
             32'h5555, 32'hBBBB, 1'b0, 1'b0, 1'b1), "stale_div", 1'b1);
    apply(idle(32'h5555, 32'hBBBB, 1'b0, 1'b0, 1'b1), "stale_div_after", 1'b1);

    // Done in the final allowed cycle wins over the timeout
    apply(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
             32'h5555, 32'hBBBB, 1'b1, 1'b0, 1'b1), "ms_clr_pre", 1'b1);
    for (int i = 0; i < 63; i++)
      apply(idle(32'h5555, 32'hBBBB, 1'b1, 1'b0, 1'b0), "unused", 1'b0);
    apply(mk(1'b0, 1'b0, 1'b1, 32'hCAFE, 32'hF00D, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
             FWD ? 32'hCAFE : 32'h5555, FWD ? 32'hF00D : 32'hBBBB, !FWD, 1'b0, 1'b0), "done_last", 1'b1);
    apply(idle(32'hCAFE, 32'hF00D, 1'b0, 1'b0, 1'b0), "done_last_commit", 1'b1);

    // Async reset mid-op, then a stale mult_done must be ignored
    apply(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
             32'hCAFE, 32'hF00D, 1'b1, 1'b0, 1'b0), "rst_start", 1'b1);
    apply(idle(32'hCAFE, 32'hF00D, 1'b1, 1'b0, 1'b0), "rst_wait", 1'b1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    apply(mk(1'b0, 1'b0, 1'b1, 32'hA, 32'hB, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
             32'h0, 32'h0, 1'b0, 1'b0, 1'b0), "stale_mult", 1'b1);
    apply(idle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0), "rst_after", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
